// File: rtl/reg_file_read_2p.sv
// rtl/reg_file_read_2p.sv - 32x32 register file, one write port, two registered read ports
// Reads see a same-edge write through forwarding; entry 0 can be tied to zero.
module reg_file_read_2p #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 5,
  parameter int ZERO_REG_EN = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  loadEnable,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic [DATA_WIDTH-1:0] inputData,
  input  logic                  readEnA,
  input  logic [ADDR_WIDTH-1:0] readAddrA,
  output logic [DATA_WIDTH-1:0] readDataA,
  output logic                  readValidA,
  input  logic                  readEnB,
  input  logic [ADDR_WIDTH-1:0] readAddrB,
  output logic [DATA_WIDTH-1:0] readDataB,
  output logic                  readValidB
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_a_q, data_b_q;
  logic [DATA_WIDTH-1:0] data_a_d, data_b_d;
  logic                  valid_a_q, valid_b_q;
  logic                  wr_en;
  logic                  zero_a, zero_b;

  // With the zero register enabled, index 0 neither stores nor forwards.
  always_comb begin
    wr_en  = loadEnable && !((ZERO_REG_EN != 0) && (writeAddr == '0));
    zero_a = (ZERO_REG_EN != 0) && (readAddrA == '0);
    zero_b = (ZERO_REG_EN != 0) && (readAddrB == '0);

    data_a_d = mem_q[readAddrA];
    if (loadEnable && (writeAddr == readAddrA)) data_a_d = inputData;
    if (zero_a) data_a_d = '0;

    data_b_d = mem_q[readAddrB];
    if (loadEnable && (writeAddr == readAddrB)) data_b_d = inputData;
    if (zero_b) data_b_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      data_a_q  <= '0;
      data_b_q  <= '0;
      valid_a_q <= 1'b0;
      valid_b_q <= 1'b0;
    end else begin
      if (wr_en) mem_q[writeAddr] <= inputData;
      valid_a_q <= readEnA;
      valid_b_q <= readEnB;
      if (readEnA) data_a_q <= data_a_d;
      if (readEnB) data_b_q <= data_b_d;
    end
  end

  assign readDataA  = data_a_q;
  assign readValidA = valid_a_q;
  assign readDataB  = data_b_q;
  assign readValidB = valid_b_q;

endmodule
